// File: rtl/flash_cmd_pkg.sv
// Shared opcodes, status-bit position and state types for the flash erase sequencer.
package flash_cmd_pkg;

  localparam logic [7:0] CMD_WREN   = 8'h06;
  localparam logic [7:0] CMD_CE     = 8'hC7;
  localparam logic [7:0] CMD_RDSR   = 8'h05;
  localparam int         SR_WIP_BIT = 0;

  localparam logic [7:0] LEN_CMD  = 8'd8;
  localparam logic [7:0] LEN_POLL = 8'd16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN_REQ,
    ST_WREN_WAIT,
    ST_ERASE_REQ,
    ST_ERASE_WAIT,
    ST_GAP,
    ST_POLL_REQ,
    ST_POLL_WAIT,
    ST_FINISH
  } erase_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ACK,
    HS_CMP
  } hs_state_e;

endpackage

// File: rtl/flash_txn_hs.sv
// Trigger/acknowledge/complete handshake with spictl, shared by every command the sequencer issues.
module flash_txn_hs
  import flash_cmd_pkg::*;
(
  input  logic sclk,
  input  logic rst,
  input  logic go,
  input  logic ctl_idle,
  output logic ctl_trig,
  output logic txn_done
);

  hs_state_e hs_q, hs_d;

  always_ff @(posedge sclk) begin
    if (rst) hs_q <= HS_IDLE;
    else     hs_q <= hs_d;
  end

  always_comb begin
    hs_d = hs_q;
    case (hs_q)
      HS_IDLE: if (go && ctl_idle) hs_d = HS_ACK;
      HS_ACK:  if (!ctl_idle)      hs_d = HS_CMP;
      HS_CMP:  if (ctl_idle)       hs_d = HS_IDLE;
      default:                     hs_d = HS_IDLE;
    endcase
  end

  // Trigger fires in the same cycle spictl reports idle so the poll gap carries one cycle of overhead.
  always_comb begin
    ctl_trig = (hs_q == HS_IDLE) && go && ctl_idle;
    txn_done = (hs_q == HS_CMP) && ctl_idle;
  end

endmodule

// File: rtl/flash_erase_seq.sv
// Chip-erase sequencer for spictl: WREN, CE, then RDSR polls until WIP clears.
// Define FLASH_ERASE_TIMEOUT_EN to abort with err after TIMEOUT_POLLS busy polls.
module flash_erase_seq
  import flash_cmd_pkg::*;
#(
  parameter int POLL_GAP      = 1000,
  parameter int TIMEOUT_POLLS = 65535,
  parameter int DATA_W        = 128
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ctl_trig,
  output logic [7:0]        ctl_len,
  output logic [DATA_W-1:0] ctl_data,
  input  logic              ctl_idle,
  input  logic [DATA_W-1:0] ctl_rdata
);

  localparam int               GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  erase_state_e     state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             go, txn_done;
  logic             unused_rdata;

  assign unused_rdata = ^ctl_rdata;

`ifdef FLASH_ERASE_TIMEOUT_EN
  localparam logic [15:0] POLL_LIMIT = 16'(TIMEOUT_POLLS);
  logic [15:0] poll_q, poll_d;
  logic        err_q, err_d;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_POLLS != 0);
  assign err = 1'b0;
`endif

  flash_txn_hs u_hs (
    .sclk     (sclk),
    .rst      (rst),
    .go       (go),
    .ctl_idle (ctl_idle),
    .ctl_trig (ctl_trig),
    .txn_done (txn_done)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
`ifdef FLASH_ERASE_TIMEOUT_EN
      poll_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
`ifdef FLASH_ERASE_TIMEOUT_EN
      poll_q  <= poll_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
`ifdef FLASH_ERASE_TIMEOUT_EN
    poll_d  = poll_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WREN_REQ;
`ifdef FLASH_ERASE_TIMEOUT_EN
        poll_d  = '0;
`endif
      end
      ST_WREN_REQ:   if (ctl_trig) state_d = ST_WREN_WAIT;
      ST_WREN_WAIT:  if (txn_done) state_d = ST_ERASE_REQ;
      ST_ERASE_REQ:  if (ctl_trig) state_d = ST_ERASE_WAIT;
      ST_ERASE_WAIT: if (txn_done) state_d = ST_GAP;
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_POLL_REQ;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_POLL_REQ:   if (ctl_trig) state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: if (txn_done) begin
`ifdef FLASH_ERASE_TIMEOUT_EN
        poll_d = poll_q + 16'd1;
        if (!ctl_rdata[SR_WIP_BIT]) begin
          state_d = ST_FINISH;
        end else if (poll_d >= POLL_LIMIT) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
`else
        state_d = ctl_rdata[SR_WIP_BIT] ? ST_GAP : ST_FINISH;
`endif
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Command encoding is held through the whole REQ/WAIT pair so spictl sees stable data.
  always_comb begin
    busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    done     = (state_q == ST_FINISH);
    go       = 1'b0;
    ctl_len  = '0;
    ctl_data = '0;
    case (state_q)
      ST_WREN_REQ, ST_WREN_WAIT: begin
        go            = (state_q == ST_WREN_REQ);
        ctl_len       = LEN_CMD;
        ctl_data[7:0] = CMD_WREN;
      end
      ST_ERASE_REQ, ST_ERASE_WAIT: begin
        go            = (state_q == ST_ERASE_REQ);
        ctl_len       = LEN_CMD;
        ctl_data[7:0] = CMD_CE;
      end
      ST_POLL_REQ, ST_POLL_WAIT: begin
        go             = (state_q == ST_POLL_REQ);
        ctl_len        = LEN_POLL;
        ctl_data[15:0] = {CMD_RDSR, 8'h00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_erase_seq.sv
// Scoreboard bench for flash_erase_seq with a behavioural spictl model driving ctl_idle/ctl_rdata.
module tb_flash_erase_seq;
  import flash_cmd_pkg::*;

  localparam int DW      = 128;
  localparam int GAP     = 10;
  localparam int TPOLLS  = 4;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    logic [7:0]    len;
    logic [DW-1:0] data;
  } txn_t;

  logic          sclk = 1'b0;
  logic          rst, start, busy, done, err, ctl_trig, ctl_idle;
  logic [7:0]    ctl_len;
  logic [DW-1:0] ctl_data, ctl_rdata;

  int   tests = 0, fails = 0, cyc = 0;
  txn_t exp_q[$];
  int   exp_evt[$];
  int   wip_ones = 0, poll_idx = 0, hold_req = 0;
  int   poll_trig_cnt = 0, last_cmp = -1000, wren_cyc = 0, st_cyc = 0, done_cnt = 0;

  flash_erase_seq #(.POLL_GAP(GAP), .TIMEOUT_POLLS(TPOLLS), .DATA_W(DW)) dut (
    .sclk(sclk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .ctl_trig(ctl_trig), .ctl_len(ctl_len), .ctl_data(ctl_data),
    .ctl_idle(ctl_idle), .ctl_rdata(ctl_rdata)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an erase is WREN, CE, then one RDSR per busy status plus the final idle one.
  task automatic push_erase(input int n_wip1, input bit timeout);
    txn_t t;
    t.len = 8'd8;  t.data = '0; t.data[7:0] = 8'h06; exp_q.push_back(t);
    t.data[7:0] = 8'hC7; exp_q.push_back(t);
    t.len = 8'd16; t.data = '0; t.data[15:0] = 16'h0500;
    for (int i = 0; i < (timeout ? TPOLLS : n_wip1 + 1); i++) exp_q.push_back(t);
    exp_evt.push_back(timeout ? EV_ERR : EV_DONE);
    wip_ones = timeout ? 32'h7fffffff : n_wip1;
    poll_idx = 0;
  endtask

  task automatic do_start(input int hold);
    if (hold > 0) begin hold_req = hold; @(negedge sclk); end
    start = 1'b1; st_cyc = cyc;
    @(negedge sclk);
    start = 1'b0;
    #4 check(busy == 1'b1, "busy_after_start", busy, 1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp_evt.size() != 0) && k < 4000) begin @(negedge sclk); k++; end
    check(k < 4000, name, k, 4000);
    repeat (30) @(negedge sclk);
    #4 check(busy == 1'b0, "idle_after_run", busy, 0);
  endtask

  // spictl model: random ack delay and transfer length; status bit 0 follows the WIP script.
  initial begin : spi_model
    bit trig_seen, active, is_poll;
    int ack_wait, busy_left, hold_left;
    trig_seen = 0; active = 0; is_poll = 0; ack_wait = 0; busy_left = 0; hold_left = 0;
    ctl_idle = 1'b1; ctl_rdata = '0;
    forever begin
      @(negedge sclk);
      if (trig_seen) begin
        active = 1; ack_wait = $urandom_range(0, 2); busy_left = $urandom_range(2, 6);
      end
      if (active) begin
        if (ack_wait > 0) begin ack_wait--; ctl_idle = 1'b1; end
        else if (busy_left > 0) begin busy_left--; ctl_idle = 1'b0; end
        else begin
          ctl_idle = 1'b1; active = 0;
          ctl_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          if (is_poll) begin poll_idx++; ctl_rdata[0] = (poll_idx <= wip_ones); end
        end
      end else if (hold_req > 0) begin
        hold_left = hold_req - 1; hold_req = 0; ctl_idle = 1'b0;
      end else if (hold_left > 0) begin
        hold_left--; ctl_idle = 1'b0;
      end else begin
        ctl_idle = 1'b1;
      end
      #4;
      trig_seen = ctl_trig && !rst;
      if (trig_seen) is_poll = (ctl_len == 8'd16);
    end
  end

  initial begin : monitor
    bit outst, saw_low, stab_en, stable_ok, prev_busy;
    logic [7:0]    t_len;
    logic [DW-1:0] t_data;
    txn_t e;
    int   ev;
    outst = 0; saw_low = 0; stab_en = 0; stable_ok = 1; prev_busy = 0;
    t_len = '0; t_data = '0;
    forever begin
      @(negedge sclk); #4;
      if (outst) begin
        if (rst) stab_en = 0;
        if (ctl_len !== t_len || ctl_data !== t_data) stable_ok = 0;
        if (!ctl_idle) saw_low = 1;
        else if (saw_low) begin
          outst = 0; last_cmp = cyc;
          if (stab_en) check(stable_ok, "cmd_stable", ctl_data, t_data);
        end
      end
      if (!rst) begin
        if (ctl_trig) begin
          check(!outst, "trig_overlap", outst, 0);
          check(ctl_idle == 1'b1, "trig_idle", ctl_idle, 1);
          check(busy == 1'b1, "trig_busy", busy, 1);
          check(exp_q.size() != 0, "trig_expected", ctl_data, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(ctl_len == e.len, "txn_len", ctl_len, e.len);
            check(ctl_data == e.data, "txn_data", ctl_data, e.data);
          end
          if (ctl_len == 8'd16) begin
            poll_trig_cnt++;
            check(cyc - last_cmp == GAP + 1, "poll_gap", cyc - last_cmp, GAP + 1);
          end
          if (ctl_len == 8'd8 && ctl_data[7:0] == 8'h06) wren_cyc = cyc;
          outst = 1; saw_low = 0; stab_en = 1; stable_ok = 1; t_len = ctl_len; t_data = ctl_data;
        end
        if (done) begin
          ev = (exp_evt.size() != 0) ? exp_evt.pop_front() : 0;
          check(ev == EV_DONE, "done_expected", ev, EV_DONE);
          check(busy == 1'b0, "busy_falls_with_done", busy, 0);
          check(prev_busy, "busy_before_done", prev_busy, 1);
          done_cnt++;
        end
        if (err) begin
          ev = (exp_evt.size() != 0) ? exp_evt.pop_front() : 0;
          check(ev == EV_ERR, "err_expected", ev, EV_ERR);
          check(busy == 1'b0, "busy_falls_with_err", busy, 0);
          check(done == 1'b0, "no_done_with_err", done, 0);
        end
      end
      prev_busy = busy && !rst;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run exceeded time limit, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n0, k, d0;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    rst = 1'b0;
    #4;
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(err == 1'b0, "rst_err", err, 0);
    check(ctl_trig == 1'b0, "rst_trig", ctl_trig, 0);
    check(ctl_len == 8'd0, "rst_len", ctl_len, 0);
    check(ctl_data == '0, "rst_data", ctl_data, 0);
    repeat (5) @(negedge sclk);

    // nominal: WIP busy twice then clear
    d0 = done_cnt;
    push_erase(2, 0); do_start(0); wait_drain("drain_nominal");
    check(done_cnt - d0 == 1, "nominal_done_count", done_cnt - d0, 1);

    // spictl not ready for 5 cycles when the erase starts
    push_erase(0, 0); do_start(5); wait_drain("drain_handshake");
    check(wren_cyc - st_cyc >= 4, "trig_after_hold", wren_cyc - st_cyc, 4);

    // extra start while busy is ignored
    d0 = done_cnt;
    push_erase(1, 0); do_start(0);
    repeat (25) @(negedge sclk);
    start = 1'b1; @(negedge sclk); start = 1'b0;
    wait_drain("drain_busy_start");
    check(done_cnt - d0 == 1, "busy_start_done_count", done_cnt - d0, 1);

    // reset while a status poll is in flight
    push_erase(3, 0); do_start(0);
    n0 = poll_trig_cnt; k = 0;
    while (poll_trig_cnt == n0 && k < 2000) begin @(negedge sclk); k++; end
    check(k < 2000, "wait_poll", k, 2000);
    check(dut.state_q == ST_POLL_WAIT, "pre_rst_state", 128'(dut.state_q), 128'(ST_POLL_WAIT));
    rst = 1'b1; start = 1'b1;
    exp_q.delete(); exp_evt.delete();
    @(negedge sclk);
    rst = 1'b0; start = 1'b0;
    #4;
    check(busy == 1'b0, "mid_rst_busy", busy, 0);
    check(ctl_trig == 1'b0, "mid_rst_trig", ctl_trig, 0);
    check(dut.state_q == ST_IDLE, "mid_rst_state", 128'(dut.state_q), 128'(ST_IDLE));
    repeat (20) @(negedge sclk);
    push_erase(0, 0); do_start(0); wait_drain("drain_after_rst");

    // randomized erases
    for (int i = 0; i < 3; i++) begin
      push_erase($urandom_range(0, 3), 0);
      do_start($urandom_range(0, 4));
      wait_drain("drain_random");
    end

`ifdef FLASH_ERASE_TIMEOUT_EN
    d0 = done_cnt;
    push_erase(0, 1); do_start(0); wait_drain("drain_timeout");
    check(done_cnt == d0, "timeout_no_done", done_cnt - d0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
